// File: rtl/tilemap_pkg.sv
// Shared definitions for the tile-map renderer: default geometry and the sequencer state encoding.
package tilemap_pkg;

  localparam int DEF_SCREEN_W      = 320;
  localparam int DEF_SCREEN_H      = 240;
  localparam int DEF_TILE_LOG2     = 5;
  localparam int DEF_MAP_COLS_LOG2 = 4;
  localparam int DEF_MAP_ROWS_LOG2 = 3;
  localparam int DEF_ID_W          = 4;
  localparam int DEF_PIX_W         = 8;
  localparam int DEF_ROM_LAT       = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/tilemap_if.sv
// Bundle of the renderer's host, map-write, sprite-ROM and frame-buffer signals.
interface tilemap_if
  import tilemap_pkg::*;
#(
  parameter int SCREEN_W      = DEF_SCREEN_W,
  parameter int SCREEN_H      = DEF_SCREEN_H,
  parameter int TILE_LOG2     = DEF_TILE_LOG2,
  parameter int MAP_COLS_LOG2 = DEF_MAP_COLS_LOG2,
  parameter int MAP_ROWS_LOG2 = DEF_MAP_ROWS_LOG2,
  parameter int ID_W          = DEF_ID_W,
  parameter int PIX_W         = DEF_PIX_W
);

  logic                                   START;
  logic [MAP_COLS_LOG2+TILE_LOG2-1:0]     SCROLL_X;
  logic [MAP_ROWS_LOG2+TILE_LOG2-1:0]     SCROLL_Y;
  logic                                   MAP_WE;
  logic [MAP_COLS_LOG2+MAP_ROWS_LOG2-1:0] MAP_ADDR;
  logic [ID_W-1:0]                        MAP_DIN;
  logic [ID_W-1:0]                        SPRITE_ID;
  logic [TILE_LOG2-1:0]                   SPRITE_X;
  logic [TILE_LOG2-1:0]                   SPRITE_Y;
  logic                                   RE;
  logic [PIX_W-1:0]                       PIXEL_DIN;
  logic [PIX_W-1:0]                       PIXEL_DOUT;
  logic [$clog2(SCREEN_W)-1:0]            PIXEL_X;
  logic [$clog2(SCREEN_H)-1:0]            PIXEL_Y;
  logic                                   WE;
  logic                                   FB_READY;
  logic                                   BUSY;
  logic                                   ENV_DONE;

  modport master (
    input  START, SCROLL_X, SCROLL_Y, MAP_WE, MAP_ADDR, MAP_DIN, PIXEL_DIN, FB_READY,
    output SPRITE_ID, SPRITE_X, SPRITE_Y, RE, PIXEL_DOUT, PIXEL_X, PIXEL_Y, WE, BUSY, ENV_DONE
  );

  modport slave (
    output START, SCROLL_X, SCROLL_Y, MAP_WE, MAP_ADDR, MAP_DIN, PIXEL_DIN, FB_READY,
    input  SPRITE_ID, SPRITE_X, SPRITE_Y, RE, PIXEL_DOUT, PIXEL_X, PIXEL_Y, WE, BUSY, ENV_DONE
  );

endinterface

// File: rtl/tilemap_ram.sv
// Tile-map storage: always-live write port, registered read with enable.
// A read and write to the same address in one cycle returns the previous contents.
module tilemap_ram #(
  parameter int AW = 7,
  parameter int DW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tilemap_engine.sv
// Scrolling tile-map renderer: raster scan -> map RAM -> sprite ROM -> frame-buffer write,
// with the whole pipeline frozen while a write is held off by the frame buffer.
//   state    | meaning
//   ST_IDLE  | waiting for START; (0,0) is issued in the START cycle itself
//   ST_RUN   | issuing one screen coordinate per unstalled cycle
//   ST_DRAIN | all coordinates issued, waiting for the last write to be accepted
module tilemap_engine
  import tilemap_pkg::*;
#(
  parameter int SCREEN_W      = DEF_SCREEN_W,
  parameter int SCREEN_H      = DEF_SCREEN_H,
  parameter int TILE_LOG2     = DEF_TILE_LOG2,
  parameter int MAP_COLS_LOG2 = DEF_MAP_COLS_LOG2,
  parameter int MAP_ROWS_LOG2 = DEF_MAP_ROWS_LOG2,
  parameter int ID_W          = DEF_ID_W,
  parameter int PIX_W         = DEF_PIX_W,
  parameter int ROM_LAT       = DEF_ROM_LAT
) (
  input logic       CLOCK_50,
  input logic       RESET_N,
  tilemap_if.master bus
);

  localparam int XW  = $clog2(SCREEN_W);
  localparam int YW  = $clog2(SCREEN_H);
  localparam int MXW = MAP_COLS_LOG2 + TILE_LOG2;
  localparam int MYW = MAP_ROWS_LOG2 + TILE_LOG2;
  localparam int AW  = MAP_COLS_LOG2 + MAP_ROWS_LOG2;
  localparam logic [XW-1:0] X_LAST = XW'(SCREEN_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_H - 1);

  state_e         state_q, state_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [MXW-1:0] scroll_x_q, scroll_x_d;
  logic [MYW-1:0] scroll_y_q, scroll_y_d;

  logic           s1_v_q;
  logic [XW-1:0]  s1_px_q;
  logic [YW-1:0]  s1_py_q;
  logic [TILE_LOG2-1:0] s1_tx_q, s1_ty_q;

  logic [ROM_LAT-1:0] rom_v_q;
  logic [XW-1:0]      rom_x_q [ROM_LAT];
  logic [YW-1:0]      rom_y_q [ROM_LAT];

  logic             we_q;
  logic [PIX_W-1:0] dout_q;
  logic [XW-1:0]    out_x_q;
  logic [YW-1:0]    out_y_q;

  logic advance, issue_valid, issue_fire, last_issue, done, re;
  logic [MXW-1:0] sx_src, mx;
  logic [MYW-1:0] sy_src, my;
  logic [AW-1:0]  rd_addr;
  logic [ID_W-1:0] tile_id;

  // The START cycle issues (0,0) using the live scroll inputs, before the latch is loaded.
  assign sx_src  = (state_q == ST_IDLE) ? bus.SCROLL_X : scroll_x_q;
  assign sy_src  = (state_q == ST_IDLE) ? bus.SCROLL_Y : scroll_y_q;
  assign mx      = MXW'(x_q) + sx_src;
  assign my      = MYW'(y_q) + sy_src;
  assign rd_addr = {my[MYW-1:TILE_LOG2], mx[MXW-1:TILE_LOG2]};

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    scroll_x_d  = scroll_x_q;
    scroll_y_d  = scroll_y_q;
    issue_valid = 1'b0;
    done        = 1'b0;
    advance     = !(we_q && !bus.FB_READY);
    last_issue  = (x_q == X_LAST) && (y_q == Y_LAST);
    unique case (state_q)
      ST_IDLE: begin
        if (bus.START) begin
          issue_valid = 1'b1;
          scroll_x_d  = bus.SCROLL_X;
          scroll_y_d  = bus.SCROLL_Y;
        end
      end
      ST_RUN:   issue_valid = 1'b1;
      ST_DRAIN: done = we_q && bus.FB_READY && (out_x_q == X_LAST) && (out_y_q == Y_LAST);
      default:  ;
    endcase
    issue_fire = issue_valid && advance;
    if (issue_fire) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      state_d = last_issue ? ST_DRAIN : ST_RUN;
    end
    if (done) state_d = ST_IDLE;
    re = advance && (issue_valid || s1_v_q || (|rom_v_q));
  end

  tilemap_ram #(
    .AW(AW),
    .DW(ID_W)
  ) u_ram (
    .clk_i   (CLOCK_50),
    .rst_ni  (RESET_N),
    .we_i    (bus.MAP_WE),
    .waddr_i (bus.MAP_ADDR),
    .wdata_i (bus.MAP_DIN),
    .re_i    (issue_fire),
    .raddr_i (rd_addr),
    .rdata_o (tile_id)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      scroll_x_q <= '0;
      scroll_y_q <= '0;
      s1_v_q     <= 1'b0;
      s1_px_q    <= '0;
      s1_py_q    <= '0;
      s1_tx_q    <= '0;
      s1_ty_q    <= '0;
      rom_v_q    <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        rom_x_q[i] <= '0;
        rom_y_q[i] <= '0;
      end
      we_q    <= 1'b0;
      dout_q  <= '0;
      out_x_q <= '0;
      out_y_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      scroll_x_q <= scroll_x_d;
      scroll_y_q <= scroll_y_d;
      if (advance) begin
        s1_v_q <= issue_fire;
        if (issue_fire) begin
          s1_px_q <= x_q;
          s1_py_q <= y_q;
          s1_tx_q <= mx[TILE_LOG2-1:0];
          s1_ty_q <= my[TILE_LOG2-1:0];
        end
      end
      // Coordinate delay line shifts in lockstep with the external ROM.
      if (re) begin
        rom_v_q[0] <= s1_v_q;
        rom_x_q[0] <= s1_px_q;
        rom_y_q[0] <= s1_py_q;
        for (int i = 1; i < ROM_LAT; i++) begin
          rom_v_q[i] <= rom_v_q[i-1];
          rom_x_q[i] <= rom_x_q[i-1];
          rom_y_q[i] <= rom_y_q[i-1];
        end
      end
      if (advance) begin
        we_q <= rom_v_q[ROM_LAT-1];
        if (rom_v_q[ROM_LAT-1]) begin
          dout_q  <= bus.PIXEL_DIN;
          out_x_q <= rom_x_q[ROM_LAT-1];
          out_y_q <= rom_y_q[ROM_LAT-1];
        end
      end
    end
  end

  assign bus.SPRITE_ID  = tile_id;
  assign bus.SPRITE_X   = s1_tx_q;
  assign bus.SPRITE_Y   = s1_ty_q;
  assign bus.RE         = re;
  assign bus.PIXEL_DOUT = dout_q;
  assign bus.PIXEL_X    = out_x_q;
  assign bus.PIXEL_Y    = out_y_q;
  assign bus.WE         = we_q;
  assign bus.BUSY       = (state_q != ST_IDLE);
  assign bus.ENV_DONE   = done;

endmodule

// File: tb/tb_tilemap_engine.sv
// Self-checking bench for tilemap_engine: a reduced screen, a behavioural ROM and
// an arithmetic map/scroll model that predicts every accepted frame-buffer write.
module tb_tilemap_engine;
  import tilemap_pkg::*;

  localparam int SW   = 80;
  localparam int SH   = 40;
  localparam int TL   = 5;
  localparam int MC   = 4;
  localparam int MR   = 3;
  localparam int IDW  = 4;
  localparam int PW   = 8;
  localparam int RL   = 1;
  localparam int NPIX = SW * SH;
  localparam int MAPW = 1 << (MC + TL);
  localparam int MAPH = 1 << (MR + TL);
  localparam int TPX  = 1 << TL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tilemap_if #(.SCREEN_W(SW), .SCREEN_H(SH), .TILE_LOG2(TL), .MAP_COLS_LOG2(MC),
               .MAP_ROWS_LOG2(MR), .ID_W(IDW), .PIX_W(PW)) bus ();

  tilemap_engine #(.SCREEN_W(SW), .SCREEN_H(SH), .TILE_LOG2(TL), .MAP_COLS_LOG2(MC),
                   .MAP_ROWS_LOG2(MR), .ID_W(IDW), .PIX_W(PW), .ROM_LAT(RL)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Sprite ROM: texel value is a fixed hash of (id, tx, ty); output advances only on RE.
  function automatic logic [PW-1:0] rom_f(input int id, input int tx, input int ty);
    return PW'((id * 29 + tx * 3 + ty * 7) % 256);
  endfunction

  logic [PW-1:0] rom_q [RL];
  always @(posedge clk) begin
    if (bus.RE) begin
      rom_q[0] <= rom_f(int'(bus.SPRITE_ID), int'(bus.SPRITE_X), int'(bus.SPRITE_Y));
      for (int i = 1; i < RL; i++) rom_q[i] <= rom_q[i-1];
    end
  end
  assign bus.PIXEL_DIN = rom_q[RL-1];

  int map_m [1 << (MC + MR)];
  int cur_sx = 0;
  int cur_sy = 0;

  function automatic logic [PW-1:0] exp_pix(input int x, input int y);
    int mx, my, tile;
    mx   = (x + cur_sx) % MAPW;
    my   = (y + cur_sy) % MAPH;
    tile = (my / TPX) * (1 << MC) + (mx / TPX);
    return rom_f(map_m[tile], mx % TPX, my % TPX);
  endfunction

  // Frame-buffer side: every accepted write is checked against the raster model.
  int exp_idx = 0;
  int frames  = 0;
  int pin_x = -1, pin_y = -1, pin_val = -1;
  bit stall_p = 1'b0;
  logic [PW-1:0] h_d;
  logic [$clog2(SW)-1:0] h_x;
  logic [$clog2(SH)-1:0] h_y;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_idx = 0;
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        chk("stall_we_hold", bus.WE, 1);
        chk("stall_dout_hold", bus.PIXEL_DOUT, h_d);
        chk("stall_x_hold", bus.PIXEL_X, h_x);
        chk("stall_y_hold", bus.PIXEL_Y, h_y);
      end
      if (bus.WE && !bus.FB_READY) begin
        chk("stall_re_low", bus.RE, 0);
        h_d = bus.PIXEL_DOUT;
        h_x = bus.PIXEL_X;
        h_y = bus.PIXEL_Y;
        stall_p = 1'b1;
      end else begin
        stall_p = 1'b0;
      end
      if (bus.WE && bus.FB_READY) begin
        int ex, ey;
        ex = exp_idx % SW;
        ey = exp_idx / SW;
        chk("pix_x", bus.PIXEL_X, ex);
        chk("pix_y", bus.PIXEL_Y, ey);
        chk("pix_val", bus.PIXEL_DOUT, exp_pix(ex, ey));
        chk("env_done_last", bus.ENV_DONE, (exp_idx == NPIX - 1) ? 1 : 0);
        if (ex == pin_x && ey == pin_y) pin_val = int'(bus.PIXEL_DOUT);
        if (exp_idx == NPIX - 1) begin
          exp_idx = 0;
          frames++;
        end else begin
          exp_idx++;
        end
      end else begin
        chk("env_done_spurious", bus.ENV_DONE, 0);
      end
      if (!bus.BUSY && !bus.START) chk("re_idle", bus.RE, 0);
    end
  end

  bit rand_rdy = 1'b0;
  initial begin
    bus.FB_READY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.FB_READY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic map_wr(input int a, input int id);
    bus.MAP_WE   = 1'b1;
    bus.MAP_ADDR = (MC + MR)'(a);
    bus.MAP_DIN  = IDW'(id);
    map_m[a]     = id;
    cyc(1);
    bus.MAP_WE   = 1'b0;
  endtask

  task automatic map_fill(input bit rnd);
    for (int a = 0; a < (1 << (MC + MR)); a++) map_wr(a, rnd ? int'($urandom_range(0, 15)) : 0);
  endtask

  task automatic start_frame(input int sx, input int sy, output int lat);
    cur_sx       = sx;
    cur_sy       = sy;
    bus.SCROLL_X = (MC + TL)'(sx);
    bus.SCROLL_Y = (MR + TL)'(sy);
    bus.START    = 1'b1;
    cyc(1);
    bus.START    = 1'b0;
    bus.SCROLL_X = (MC + TL)'($urandom);
    bus.SCROLL_Y = (MR + TL)'($urandom);
    lat = 1;
    while (!bus.WE && lat < 20) begin
      cyc(1);
      lat++;
    end
  endtask

  task automatic wait_done(input int budget);
    int n, f0;
    n  = 0;
    f0 = frames;
    while (frames == f0 && n < budget) begin
      cyc(1);
      n++;
    end
    chk("frame_completed", (frames != f0) ? 1 : 0, 1);
  endtask

  initial begin
    int lat, quiet;
    bus.START    = 1'b0;
    bus.MAP_WE   = 1'b0;
    bus.MAP_ADDR = '0;
    bus.MAP_DIN  = '0;
    bus.SCROLL_X = '0;
    bus.SCROLL_Y = '0;
    rst_n = 1'b0;
    cyc(3);
    chk("rst_we", bus.WE, 0);
    chk("rst_re", bus.RE, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_done", bus.ENV_DONE, 0);
    chk("rst_dout", bus.PIXEL_DOUT, 0);
    chk("rst_px", bus.PIXEL_X, 0);
    chk("rst_py", bus.PIXEL_Y, 0);
    chk("rst_sid", bus.SPRITE_ID, 0);
    chk("rst_sx", bus.SPRITE_X, 0);
    chk("rst_sy", bus.SPRITE_Y, 0);
    rst_n = 1'b1;
    cyc(1);

    // Frame 1: blank map, no scroll, no backpressure; exact latency and done timing.
    map_fill(1'b0);
    start_frame(0, 0, lat);
    chk("first_we_latency", lat, 3);
    cyc(NPIX - 1);
    chk("done_cycle", bus.ENV_DONE, 1);
    bus.START = 1'b1;
    cyc(1);
    bus.START = 1'b0;
    chk("start_in_done_ignored", bus.BUSY, 0);
    cyc(5);
    chk("idle_after_frame", bus.BUSY, 0);
    chk("frames_after_f1", frames, 1);
    chk("no_extra_writes_f1", exp_idx, 0);

    // Frame 2: random map with tile {0,1} = 5.
    map_fill(1'b1);
    map_wr(1, 5);
    pin_x = 40; pin_y = 5; pin_val = -1;
    start_frame(0, 0, lat);
    chk("latency_f2", lat, 3);
    wait_done(5000);
    chk("pin_tile01_texel", pin_val, 204);

    // Frame 3: wrapping scroll, random backpressure, START pulsed mid-frame.
    map_wr(0, 9);
    pin_x = 20; pin_y = 10; pin_val = -1;
    rand_rdy = 1'b1;
    start_frame(500, 250, lat);
    chk("latency_f3", lat, 3);
    cyc(400);
    bus.START = 1'b1;
    cyc(1);
    bus.START = 1'b0;
    wait_done(12000);
    chk("pin_scroll_wrap", pin_val, 57);
    chk("frames_after_f3", frames, 3);

    // Frame 4: aborted by a one-cycle reset.
    pin_x = -1; pin_y = -1;
    start_frame(int'($urandom_range(0, MAPW - 1)), int'($urandom_range(0, MAPH - 1)), lat);
    chk("latency_f4", lat, 3);
    cyc(300);
    bus.START = 1'b1;
    cyc(1);
    bus.START = 1'b0;
    cyc(200);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("abort_we", bus.WE, 0);
    chk("abort_busy", bus.BUSY, 0);
    quiet = 0;
    repeat (30) begin
      cyc(1);
      if (bus.WE || bus.BUSY || bus.ENV_DONE) quiet++;
    end
    chk("abort_quiet", quiet, 0);
    chk("frames_after_abort", frames, 3);

    // Frame 5: clean restart; tile {0,2} rewritten while the scan is still in tile 0.
    map_wr(2, 3);
    pin_x = 64; pin_y = 0; pin_val = -1;
    start_frame(0, 0, lat);
    chk("latency_f5", lat, 3);
    map_wr(2, 11);
    wait_done(12000);
    chk("pin_live_map_write", pin_val, 63);
    chk("frames_after_f5", frames, 4);
    cyc(5);
    chk("no_extra_writes_f5", exp_idx, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
